// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   // Divide ops use the restoring-division datapath mode.
   function automatic logic is_div(input logic [1:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Signed ops work on magnitudes and fix the sign at the end.
   function automatic logic is_signed(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shared shift/add-subtract datapath.
// mode=0: shift-add multiply step, acc = {partial_hi, multiplier/product_lo}.
// mode=1: restoring divide step, acc = {remainder, dividend/quotient};
//         the new quotient bit is returned in qbit and left as 0 in acc_nxt.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   operand,
   input  logic               mode,
   output logic [2*WIDTH-1:0] acc_nxt,
   output logic               qbit
);

   logic [WIDTH:0]   addend;
   logic [WIDTH:0]   sum;
   logic [2*WIDTH:0] shl;
   logic [WIDTH-1:0] diff;

   // Compute both step flavours and pick by mode.
   always_comb begin
      acc_nxt = '0;
      qbit    = 1'b0;
      addend  = acc[0] ? {1'b0, operand} : '0;
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
      // The shifted remainder needs W+1 bits before the trial subtract.
      shl     = {acc, 1'b0};
      // Only used when the subtract succeeds, so the result fits in W bits.
      diff    = shl[2*WIDTH-1:WIDTH] - operand;
      if (mode) begin
         qbit    = (shl[2*WIDTH:WIDTH] >= {1'b0, operand});
         acc_nxt = qbit ? {diff, shl[WIDTH-1:0]} : shl[2*WIDTH-1:0];
      end else begin
         acc_nxt = {sum, acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit feeding registered HI/LO.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

   state_t             state;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [CNT_W-1:0]   cnt;
   logic               qbit;
   logic               mode_div;
   logic               neg_res;
   logic               neg_rem;
   logic               div0_pend;

   // Magnitudes of the operands; MIN_INT maps onto itself as an unsigned value.
   assign a_abs = (is_signed(op) && a[WIDTH-1]) ? -a : a;
   assign b_abs = (is_signed(op) && b[WIDTH-1]) ? -b : b;

   // Sign correction applied on the FIX edge.
   assign prod = neg_res ? -acc : acc;
   assign quot = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc     (acc),
      .operand (opnd),
      .mode    (mode_div),
      .acc_nxt (acc_nxt),
      .qbit    (qbit)
   );

   // Control FSM and datapath registers; cancel outranks start and iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         div0      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
         acc       <= '0;
         opnd      <= '0;
         mode_div  <= 1'b0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         div0_pend <= 1'b0;
      end else begin
         done <= 1'b0;
         if (cancel) begin
            if (state != IDLE) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         end else begin
            case (state)
               IDLE: if (start) begin
                  busy     <= 1'b1;
                  div0     <= 1'b0;
                  mode_div <= is_div(op);
                  neg_res  <= is_signed(op) && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem  <= is_signed(op) && a[WIDTH-1];
                  // Multiplier bits (or dividend bits) shift through acc low half.
                  acc      <= is_div(op) ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                  opnd     <= is_div(op) ? b_abs : a_abs;
                  cnt      <= '0;
                  if (is_div(op) && (b == '0)) begin
                     div0_pend <= 1'b1;
                     state     <= FIX;
                  end else begin
                     div0_pend <= 1'b0;
                     state     <= RUN;
                  end
               end
               RUN: begin
                  acc <= {acc_nxt[2*WIDTH-1:1], acc_nxt[0] | qbit};
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST) state <= FIX;
               end
               FIX: begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (div0_pend) begin
                     div0 <= 1'b1;
                  end else begin
                     hi <= mode_div ? rem  : prod[2*WIDTH-1:WIDTH];
                     lo <= mode_div ? quot : prod[WIDTH-1:0];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on done.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        d0;
      int          t0;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, cancel;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div0;
   logic [31:0] hi, lo;

   logic        s_start, s_cancel;
   logic [1:0]  s_op;
   logic [7:0]  a8, b8, hi8, lo8;
   logic [15:0] a16, b16, hi16, lo16;
   logic        busy8, done8, div08, busy16, done16, div016;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q32[$];
   exp_t q8[$];
   exp_t q16[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   muldiv_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .cancel(cancel),
      .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo));

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .cancel(s_cancel),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8));

   muldiv_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .cancel(s_cancel),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .div0(div016), .hi(hi16), .lo(lo16));

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", n, act, exp);
      end
   endtask

   // Reference model for the narrow-width instances.
   function automatic exp_t model(input int w, input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, input logic [31:0] ph, input logic [31:0] pl);
      exp_t   e;
      longint m, half, ux, uy, sx, sy, p, q, r;
      m    = (longint'(1) <<< w) - 1;
      half = longint'(1) <<< (w-1);
      ux   = longint'(x) & m;
      uy   = longint'(y) & m;
      sx   = (ux ^ half) - half;
      sy   = (uy ^ half) - half;
      e.d0 = 1'b0; e.lat = w + 1; e.t0 = 0; e.hi = 0; e.lo = 0;
      if (o == OP_MULT || o == OP_MULTU) begin
         p    = (o == OP_MULT) ? sx * sy : ux * uy;
         e.hi = 32'((p >>> w) & m);
         e.lo = 32'(p & m);
      end else if (uy == 0) begin
         e.d0 = 1'b1; e.lat = 1; e.hi = ph; e.lo = pl;
      end else begin
         if (o == OP_DIV) begin q = sx / sy; r = sx % sy; end
         else begin q = ux / uy; r = ux % uy; end
         e.hi = 32'(r & m);
         e.lo = 32'(q & m);
      end
      return e;
   endfunction

   // Monitor for the 32-bit instance.
   always @(negedge clk) if (rst_n && done) begin
      exp_t e;
      if (q32.size() == 0) chk("unexpected_done32", 1, 0);
      else begin
         e = q32.pop_front();
         chk("hi32", hi, e.hi);
         chk("lo32", lo, e.lo);
         chk("div0_32", div0, e.d0);
         chk("lat32", cyc - e.t0, e.lat);
         chk("busy_at_done32", busy, 0);
      end
   end

   // Monitor for the 8-bit instance.
   always @(negedge clk) if (rst_n && done8) begin
      exp_t e;
      if (q8.size() == 0) chk("unexpected_done8", 1, 0);
      else begin
         e = q8.pop_front();
         chk("hi8", hi8, e.hi);
         chk("lo8", lo8, e.lo);
         chk("div0_8", div08, e.d0);
         chk("lat8", cyc - e.t0, e.lat);
      end
   end

   // Monitor for the 16-bit instance.
   always @(negedge clk) if (rst_n && done16) begin
      exp_t e;
      if (q16.size() == 0) chk("unexpected_done16", 1, 0);
      else begin
         e = q16.pop_front();
         chk("hi16", hi16, e.hi);
         chk("lo16", lo16, e.lo);
         chk("div0_16", div016, e.d0);
         chk("lat16", cyc - e.t0, e.lat);
      end
   end

   task automatic drain(input int budget);
      int n = 0;
      while ((q32.size() + q8.size() + q16.size()) != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if ((q32.size() + q8.size() + q16.size()) != 0) begin
         chk("timeout_pending", q32.size() + q8.size() + q16.size(), 0);
         q32.delete(); q8.delete(); q16.delete();
      end
   endtask

   task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit push, input logic [31:0] eh, input logic [31:0] el);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (push) begin
         e.hi = eh; e.lo = el; e.d0 = o[1] && (y == 0);
         e.t0 = cyc + 1; e.lat = e.d0 ? 1 : 33;
         q32.push_back(e);
      end
      @(negedge clk);
      // Scramble inputs after acceptance: the operation must use latched values.
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0;
      exp_t e;
      logic [31:0] ph8, pl8, ph16, pl16;
      rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = 0; b = 0;
      s_start = 1'b0; s_cancel = 1'b0; s_op = 2'b00; a8 = 0; b8 = 0; a16 = 0; b16 = 0;
      ph8 = 0; pl8 = 0; ph16 = 0; pl16 = 0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_div0", div0, 0);
      chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
      chk("rst_busy8", busy8, 0); chk("rst_busy16", busy16, 0);
      rst_n = 1'b1;

      // Signed multiply with one negative operand, plus latency.
      issue32(OP_MULT, 32'hFFFFFFFD, 32'd5, 1, 32'hFFFFFFFF, 32'hFFFFFFF1);
      chk("busy_run", busy, 1);
      drain(60);
      chk("busy_idle", busy, 0);

      // Unsigned multiply; a start while busy must be ignored.
      issue32(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001);
      repeat (5) @(negedge clk);
      start = 1'b1; op = OP_DIV; a = 32'd9; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      drain(60);
      repeat (40) @(negedge clk);

      // Signed divide, truncating toward zero.
      issue32(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD);
      drain(60);
      // Overflow case MIN_INT / -1.
      issue32(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000);
      drain(60);

      // Unsigned divide with a second start in the done cycle.
      issue32(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14);
      t0 = cyc;
      while (cyc < t0 + 33) @(negedge clk);
      chk("done_b2b", done, 1);
      start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd33;
      e.hi = 32'd10; e.lo = 32'd30; e.d0 = 1'b0; e.t0 = cyc + 1; e.lat = 33;
      q32.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_b2b", busy, 1);
      drain(80);

      // Divide by zero keeps hi/lo; next start clears div0.
      issue32(OP_DIV, 32'd5, 32'd0, 1, 32'd10, 32'd30);
      drain(10);
      repeat (3) @(negedge clk);
      chk("div0_hold", div0, 1);
      chk("div0_hi_keep", hi, 32'd10);
      chk("div0_lo_keep", lo, 32'd30);
      issue32(OP_MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42);
      chk("div0_cleared", div0, 0);
      drain(60);

      // Cancel in RUN: no done, outputs unchanged.
      issue32(OP_MULT, 32'd3, 32'd4, 0, 0, 0);
      t0 = cyc;
      while (cyc < t0 + 10) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("busy_cancel", busy, 0);
      repeat (40) @(negedge clk);
      chk("hi_after_cancel", hi, 32'd0);
      chk("lo_after_cancel", lo, 32'd42);

      // Cancel together with start in IDLE drops the start.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("busy_idle_cancel", busy, 0);
      repeat (40) @(negedge clk);

      // Asynchronous reset mid-operation.
      issue32(OP_MULTU, 32'hFF, 32'hFF, 0, 0, 0);
      t0 = cyc;
      while (cyc < t0 + 5) @(negedge clk);
      chk("busy_before_rst", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", busy, 0); chk("mrst_done", done, 0); chk("mrst_div0", div0, 0);
      chk("mrst_hi", hi, 0); chk("mrst_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("busy_after_rst", busy, 0);

      // Narrow widths against the reference model.
      for (int i = 0; i < 24; i++) begin
         logic [1:0]  o;
         logic [15:0] x, y;
         logic [7:0]  x8, y8;
         exp_t        e8, e16;
         o  = 2'(i % 4);
         x  = 16'($urandom);
         y  = 16'($urandom);
         if (i % 6 == 5) y = 16'h0;
         x8 = x[7:0];
         y8 = y[7:0];
         if (i == 2) begin
            x8 = 8'h80; y8 = 8'hFF; x = 16'h8000; y = 16'hFFFF;
         end
         @(negedge clk);
         s_start = 1'b1; s_op = o; a8 = x8; b8 = y8; a16 = x; b16 = y;
         e8  = model(8,  o, {24'h0, x8}, {24'h0, y8}, ph8, pl8);
         e16 = model(16, o, {16'h0, x},  {16'h0, y},  ph16, pl16);
         e8.t0  = cyc + 1;
         e16.t0 = cyc + 1;
         if (!e8.d0)  begin ph8  = e8.hi;  pl8  = e8.lo;  end
         if (!e16.d0) begin ph16 = e16.hi; pl16 = e16.lo; end
         q8.push_back(e8);
         q16.push_back(e16);
         @(negedge clk);
         s_start = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         drain(60);
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
